desc_word_packer: RTL
=====================

Name: desc_word_packer

Overview:
- Upstream feeder for the NCC descriptor-load path.
- Accepts the template descriptor as a byte-wide pixel stream with a valid/ready handshake.
- Packs every 4 pixels into one 32-bit word and issues exactly numPixelsDesc/4 single-cycle desc_data_ready strobes per descriptor.
- Word order matches the NCC grid fill order: row-major, 4 words per 16-pixel row.

Parameters:
numPixelsDesc, 256, pixels per descriptor; must be a multiple of 4 (16x16 grid).
pixelWidth, 8, bits per input pixel; fixed at 8 (4 x 8 = 32-bit word).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low; one clock.
desc_start  in  1  1-cycle pulse: begin loading a new descriptor.
desc_abort  in  1  drop the load in progress and return to IDLE.
pixel_valid  in  1  pixel_in is valid this cycle.
pixel_in  in  8  descriptor pixel, unsigned.
pixel_ready  out  1  block accepts pixel_in this cycle.
desc_data_ready  out  1  1-cycle strobe: desc_data_in holds a packed word.
desc_data_in  out  32  packed word; first pixel of the group in [31:24], last in [7:0].
desc_busy  out  1  load in progress (state LOAD or FLUSH).
desc_loaded  out  1  1-cycle pulse after the final word strobe.
word_count  out  $clog2(numPixelsDesc/4)+1  words emitted for the current descriptor.

Behaviour:
- Reset (rst_n=0, async): state IDLE.
  - All outputs 0; shift register, byte counter and word counter cleared.
- States and transitions:
  - IDLE: pixel_ready=0. desc_start=1 -> LOAD, clearing the byte counter, word counter and word_count.
  - LOAD: pixel_ready=1. Transfer occurs when pixel_valid & pixel_ready.
    - On each transfer: shift reg <= {shift[23:0], pixel_in}; byte counter +1, mod 4.
    - On the transfer with byte counter=3: register the packed word into desc_data_in and assert desc_data_ready on the next cycle, for exactly 1 cycle.
    - Latency: 4th-pixel accept edge -> strobe visible the following cycle.
    - word_count increments in the same cycle desc_data_ready is high.
    - When the transfer completes word numPixelsDesc/4: -> FLUSH; pixel_ready drops the cycle after that 4th-byte accept.
  - FLUSH: desc_data_ready high with the final word (1 cycle), then -> DONE.
  - DONE: desc_loaded=1 for 1 cycle, then -> IDLE. desc_data_in holds its last value until the next strobe.
- Strobes:
  - desc_data_ready is never high on two consecutive cycles more often than transfers allow.
  - Maximum rate is 1 strobe per 4 cycles.
  - Downstream has no backpressure; every strobe is consumed.
- Ignored inputs:
  - pixel_valid while not in LOAD is ignored; no transfer.
  - desc_start while busy is ignored.
- desc_abort (any state other than IDLE):
  - -> IDLE next cycle; partial word discarded; no further strobe; desc_loaded not pulsed; word_count cleared.
  - Abort has priority over a coincident transfer.
  - Abort together with desc_start in IDLE: start wins.
- Downstream consequence: after an abort, the downstream row/column counters are out of phase. A full descriptor must then be reloaded only after the downstream block is reset. Verification must check this sequence.
- Reset mid-load: immediate return to IDLE, outputs cleared; no spurious strobe on reset release.
- Pixel value 0 is passed unchanged (log2 conversion happens downstream).
- Gaps (pixel_valid=0) inside a group stall packing without losing bytes.

Decomposition:
- Shared package ncc_pkg:
  - typedef state enum {IDLE, LOAD, FLUSH, DONE};
  - constants PIXELS_PER_WORD=4 and WORDS_PER_DESC=numPixelsDesc/4.
- Reuse the existing counter module for the byte and word counters.
- One natural sub-module: pixel_shift_packer (4-byte shift register + group-complete flag).
- FSM and strobe logic stay in the top.

Test Plan:
1. Reset released, desc_start, 256 pixels with values 0..255 back-to-back -> 64 strobes every 4th cycle; word 0 = 0x00010203, word 63 = 0xFCFDFEFF; desc_loaded pulses 2 cycles after the last strobe; word_count=64.
2. Same stream with pixel_valid toggled 1/0 each cycle -> identical 64 words, strobes every 8 cycles, no byte lost or duplicated.
3. desc_abort after 6 pixels (0xA0..0xA5) -> exactly 1 strobe (0xA0A1A2A3); IDLE next cycle; pixel_ready=0; no desc_loaded; word_count=0.
4. desc_start pulsed at pixel 100 of an active load -> ignored; still 64 words total, contents unchanged.
5. rst_n asserted asynchronously mid-cycle during word 10 -> all outputs 0 immediately; no strobe after release until a new desc_start.
6. pixel_valid=1 with 0x55 while IDLE for 10 cycles, then start and 256 x 0x00 -> first word 0x00000000 (no stale 0x55 bytes); 64 strobes.

Source files
------------

// File: rtl/ncc_pkg.sv
// ============================================================================
// Module      : ncc_pkg
// Description : Shared types and constants for the NCC descriptor-load path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ncc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int PIXELS_PER_WORD = 4;
    localparam int NUM_PIXELS_DESC = 256;
    localparam int WORDS_PER_DESC  = NUM_PIXELS_DESC / PIXELS_PER_WORD;

    function automatic int words_per_desc(input int num_pixels);
        return num_pixels / PIXELS_PER_WORD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ncc_counter.sv
// ============================================================================
// Module      : ncc_counter
// Description : Modulo-N up-counter with synchronous clear and count enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ncc_counter #(
    parameter int WIDTH  = 2,
    parameter int MODULO = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= (count_q == c_LAST) ? '0 : count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pixel_shift_packer.sv
// ============================================================================
// Module      : pixel_shift_packer
// Description : Byte shift register that assembles pixel groups into words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_shift_packer
    import ncc_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr_i,
    input  logic                                 shift_en_i,
    input  logic                                 last_byte_i,
    input  logic [PIXEL_WIDTH-1:0]               pixel_i,
    output logic [PIXELS_PER_WORD*PIXEL_WIDTH-1:0] word_o,
    output logic                                 group_done_o
);

    localparam int c_HELD_W = (PIXELS_PER_WORD - 1) * PIXEL_WIDTH;

    // Only the first three bytes are held; the fourth flows straight from the
    // input into the packed word on the group-completing transfer.
    logic [c_HELD_W-1:0] shift_q;

    assign word_o       = {shift_q, pixel_i};
    assign group_done_o = shift_en_i & last_byte_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (clr_i) begin
            shift_q <= '0;
        end else if (shift_en_i) begin
            shift_q <= word_o[c_HELD_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/desc_word_packer.sv
// ============================================================================
// Module      : desc_word_packer
// Description : Packs a byte-wide descriptor pixel stream into 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module desc_word_packer
    import ncc_pkg::*;
#(
    parameter int NUM_PIXELS_DESC = 256,
    parameter int PIXEL_WIDTH     = 8
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            desc_start,
    input  logic                                            desc_abort,
    input  logic                                            pixel_valid,
    input  logic [PIXEL_WIDTH-1:0]                          pixel_in,
    output logic                                            pixel_ready,
    output logic                                            desc_data_ready,
    output logic [PIXELS_PER_WORD*PIXEL_WIDTH-1:0]          desc_data_in,
    output logic                                            desc_busy,
    output logic                                            desc_loaded,
    output logic [$clog2(NUM_PIXELS_DESC/PIXELS_PER_WORD):0] word_count
);

    localparam int c_WORDS  = words_per_desc(NUM_PIXELS_DESC);
    localparam int c_WC_W   = $clog2(c_WORDS) + 1;
    localparam int c_BC_W   = $clog2(PIXELS_PER_WORD);
    localparam int c_WORD_W = PIXELS_PER_WORD * PIXEL_WIDTH;

    localparam logic [c_WC_W-1:0] c_LAST_WORD = c_WC_W'(c_WORDS - 1);
    localparam logic [c_BC_W-1:0] c_LAST_BYTE = c_BC_W'(PIXELS_PER_WORD - 1);

    state_e              state_q;
    logic                pixel_ready_q;
    logic                data_ready_q;
    logic [c_WORD_W-1:0] data_q;
    logic                busy_q;
    logic                loaded_q;

    logic [c_BC_W-1:0]   w_byte_cnt;
    logic [c_WC_W-1:0]   w_word_cnt;
    logic [c_WORD_W-1:0] w_packed;
    logic                w_group_done;
    logic                w_abort;
    logic                w_clr;
    logic                w_shift;

    // Abort outranks any coincident transfer; start wins only from IDLE.
    assign w_abort = desc_abort & (state_q != IDLE);
    assign w_clr   = ((state_q == IDLE) & desc_start) | w_abort;
    assign w_shift = pixel_valid & pixel_ready_q & ~w_abort;

    ncc_counter #(
        .WIDTH  (c_BC_W),
        .MODULO (PIXELS_PER_WORD)
    ) u_byte_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (w_clr),
        .en_i    (w_shift),
        .count_o (w_byte_cnt)
    );

    ncc_counter #(
        .WIDTH  (c_WC_W),
        .MODULO (c_WORDS + 1)
    ) u_word_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (w_clr),
        .en_i    (w_group_done),
        .count_o (w_word_cnt)
    );

    pixel_shift_packer #(
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (w_clr),
        .shift_en_i   (w_shift),
        .last_byte_i  (w_byte_cnt == c_LAST_BYTE),
        .pixel_i      (pixel_in),
        .word_o       (w_packed),
        .group_done_o (w_group_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pixel_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            loaded_q      <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            loaded_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (desc_start) begin
                        state_q       <= LOAD;
                        pixel_ready_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_abort) begin
                        state_q       <= IDLE;
                        pixel_ready_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end else if (w_group_done) begin
                        data_q       <= w_packed;
                        data_ready_q <= 1'b1;
                        if (w_word_cnt == c_LAST_WORD) begin
                            state_q       <= FLUSH;
                            pixel_ready_q <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state_q <= w_abort ? IDLE : DONE;
                    busy_q  <= 1'b0;
                end
                DONE: begin
                    // Completion pulse is registered out of DONE, so it
                    // appears two cycles after the final word strobe.
                    state_q  <= IDLE;
                    loaded_q <= ~desc_abort;
                end
                default: begin
                    state_q       <= IDLE;
                    pixel_ready_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_ready     = pixel_ready_q;
    assign desc_data_ready = data_ready_q;
    assign desc_data_in    = data_q;
    assign desc_busy       = busy_q;
    assign desc_loaded     = loaded_q;
    assign word_count      = w_word_cnt;

endmodule

`default_nettype wire
